// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampled UART receiver with mid-bit majority vote
// Emits one framed character per strobe; flags bad stop bits and waits out line breaks.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_in,
  output logic [DATA_BITS-1:0] char_out,
  output logic                 char_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int              IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]      CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] char_out_n;
  logic                 char_valid_n, frame_error_n;
  logic                 s1, s2;
  logic                 samp7, samp8, samp7_n, samp8_n;
  logic                 vote;

  // Third vote sample is the live synchronised line at cnt 9.
  assign vote = (samp7 & samp8) | (samp7 & s2) | (samp8 & s2);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      samp7       <= 1'b1;
      samp8       <= 1'b1;
      char_out    <= '0;
      char_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      s1          <= uart_in;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      samp7       <= samp7_n;
      samp8       <= samp8_n;
      char_out    <= char_out_n;
      char_valid  <= char_valid_n;
      frame_error <= frame_error_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    shreg_n       = shreg;
    char_out_n    = char_out;
    char_valid_n  = 1'b0;
    frame_error_n = 1'b0;
    samp7_n       = (cnt == 4'd7) ? s2 : samp7;
    samp8_n       = (cnt == 4'd8) ? s2 : samp8;

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        // The detection cycle is sample 0 of the start bit, hence cnt starts at 1.
        if (!s2) begin
          state_n = START;
          cnt_n   = 4'd1;
        end
      end
      START: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd9 && vote) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd9) shreg_n = {vote, shreg[DATA_BITS-1:1]};
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (idx == IDX_LAST) state_n = STOP;
          else                 idx_n   = idx + IDX_W'(1);
        end
      end
      STOP: begin
        cnt_n = cnt + 4'd1;
        // Leave half a bit early so a following start edge is not missed.
        if (cnt == 4'd9) begin
          cnt_n = '0;
          if (vote) begin
            char_out_n   = shreg;
            char_valid_n = 1'b1;
            state_n      = IDLE;
          end else begin
            frame_error_n = 1'b1;
            state_n       = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (s2) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - directed bench for uart_rx_oversample
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_in;
  logic [7:0] char_out;
  logic       char_valid;
  logic       frame_error;
  logic       busy;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .uart_in(uart_in),
    .char_out(char_out), .char_valid(char_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] v_vals[$];
  int         v_cycs[$];
  logic       v_busy[$];
  logic       v_prev_busy[$];
  int         f_cycs[$];
  int         both_high = 0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (char_valid === 1'b1) begin
      v_vals.push_back(char_out);
      v_cycs.push_back(cyc);
      v_busy.push_back(busy);
      v_prev_busy.push_back(prev_busy);
    end
    if (frame_error === 1'b1) f_cycs.push_back(cyc);
    if (char_valid === 1'b1 && frame_error === 1'b1) both_high++;
    prev_busy = busy;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      uart_in = v;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; e0 is the index of the posedge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input bit noise, input logic stop_v, output int e0);
    e0 = cyc + 1;
    drive(1'b0, 16);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 16; j++) begin
        uart_in = d[k] ^ (noise && j == 8);
        @(negedge clk);
      end
    drive(stop_v, 16);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         noise;
    logic [7:0] exp_char;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, e1, nv, nf;

    vecs[0] = '{data: 8'h41, noise: 1'b0, exp_char: 8'h41};
    vecs[1] = '{data: 8'hA5, noise: 1'b1, exp_char: 8'hA5};
    vecs[2] = '{data: 8'h00, noise: 1'b0, exp_char: 8'h00};
    vecs[3] = '{data: 8'hFF, noise: 1'b1, exp_char: 8'hFF};

    reset   = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset char_out", char_out, 8'h00);
    chk("reset char_valid", char_valid, 1'b0);
    chk("reset frame_error", frame_error, 1'b0);
    chk("reset busy", busy, 1'b0);
    reset = 1'b0;
    drive(1'b1, 4);

    for (int i = 0; i < 4; i++) begin
      nv = v_vals.size();
      nf = f_cycs.size();
      send_frame(vecs[i].data, vecs[i].noise, 1'b1, e0);
      drive(1'b1, 8);
      chk($sformatf("vec%0d strobe count", i), v_vals.size() - nv, 1);
      if (v_vals.size() > nv) begin
        chk($sformatf("vec%0d value", i), v_vals[nv], vecs[i].exp_char);
        chk($sformatf("vec%0d latency", i), v_cycs[nv] - e0, 155);
        chk($sformatf("vec%0d busy at strobe", i), v_busy[nv], 1'b0);
        chk($sformatf("vec%0d busy before strobe", i), v_prev_busy[nv], 1'b1);
      end
      chk($sformatf("vec%0d no frame_error", i), f_cycs.size() - nf, 0);
      chk($sformatf("vec%0d char_out", i), char_out, vecs[i].exp_char);
    end

    // Start-bit glitch: 4 low cycles must be rejected by E11.
    nv = v_vals.size();
    nf = f_cycs.size();
    drive(1'b0, 4);
    drive(1'b1, 7);
    chk("glitch busy at E10", busy, 1'b1);
    drive(1'b1, 1);
    chk("glitch idle at E11", busy, 1'b0);
    drive(1'b1, 20);
    chk("glitch no strobe", v_vals.size() - nv, 0);
    chk("glitch no error", f_cycs.size() - nf, 0);
    chk("glitch char_out kept", char_out, 8'hFF);

    // Framing error followed by a held-low line.
    nv = v_vals.size();
    nf = f_cycs.size();
    send_frame(8'h3C, 1'b0, 1'b0, e0);
    chk("ferr pulse count", f_cycs.size() - nf, 1);
    if (f_cycs.size() > nf) chk("ferr latency", f_cycs[nf] - e0, 155);
    chk("ferr no strobe", v_vals.size() - nv, 0);
    chk("ferr char_out kept", char_out, 8'hFF);
    drive(1'b0, 100);
    chk("break no extra error", f_cycs.size() - nf, 1);
    chk("break no strobe", v_vals.size() - nv, 0);
    chk("break busy held", busy, 1'b1);
    drive(1'b1, 4);
    chk("break released idle", busy, 1'b0);
    drive(1'b1, 8);

    // Back-to-back frames with full stop bits and no idle gap.
    nv = v_vals.size();
    nf = f_cycs.size();
    send_frame(8'h55, 1'b0, 1'b1, e0);
    send_frame(8'hAA, 1'b0, 1'b1, e1);
    drive(1'b1, 8);
    chk("b2b strobe count", v_vals.size() - nv, 2);
    if (v_vals.size() > nv + 1) begin
      chk("b2b first value", v_vals[nv], 8'h55);
      chk("b2b second value", v_vals[nv+1], 8'hAA);
      chk("b2b spacing", v_cycs[nv+1] - v_cycs[nv], 160);
      chk("b2b second latency", v_cycs[nv+1] - e1, 155);
    end
    chk("b2b no error", f_cycs.size() - nf, 0);

    // Reset asserted for one cycle during data bit 3 of 0x7E.
    nv = v_vals.size();
    nf = f_cycs.size();
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b1, 8);
    reset   = 1'b1;
    uart_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset char_out", char_out, 8'h00);
    chk("midreset char_valid", char_valid, 1'b0);
    chk("midreset frame_error", frame_error, 1'b0);
    chk("midreset busy", busy, 1'b0);
    drive(1'b1, 30);
    chk("midreset no strobe", v_vals.size() - nv, 0);
    send_frame(8'h7E, 1'b0, 1'b1, e0);
    drive(1'b1, 8);
    chk("after reset strobe count", v_vals.size() - nv, 1);
    if (v_vals.size() > nv) begin
      chk("after reset value", v_vals[nv], 8'h7E);
      chk("after reset latency", v_cycs[nv] - e0, 155);
    end
    chk("after reset no error", f_cycs.size() - nf, 0);
    chk("valid and error never together", both_high, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
